// File: rtl/alu_pipe.sv
// Two-stage pipelined dual-mode ALU with valid/ready handshakes, a transaction tag
// and zero/overflow/illegal-op status flags.
module alu_pipe #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             a_en,
    input  logic             b_en,
    input  logic [2:0]       a_op,
    input  logic [1:0]       b_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   C,
    output logic [TAG_W-1:0] out_tag,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    localparam int unsigned RW = WIDTH + 1;

    // Encoding is {a_en, b_en}
    typedef enum logic [1:0] {
        MODE_NONE = 2'b00,
        MODE_B1   = 2'b01,
        MODE_A    = 2'b10,
        MODE_B2   = 2'b11
    } mode_e;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    mode_e            s1_mode;
    logic [2:0]       s1_aop;
    logic [1:0]       s1_bop;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_load;
    logic [RW-1:0]    ax;
    logic [RW-1:0]    bx;
    logic [RW-1:0]    res;
    logic             arith;
    logic             illegal;
    logic             res_ovf;

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;

    // Stage 1: operand/opcode/tag capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_mode  <= MODE_NONE;
            s1_aop   <= '0;
            s1_bop   <= '0;
            s1_tag   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a    <= A;
                s1_b    <= B;
                s1_mode <= mode_e'({a_en, b_en});
                s1_aop  <= a_op;
                s1_bop  <= b_op;
                s1_tag  <= in_tag;
            end
        end
    end

    // Operation decode on sign-extended operands; illegal combinations yield zero
    always_comb begin
        ax      = {s1_a[WIDTH-1], s1_a};
        bx      = {s1_b[WIDTH-1], s1_b};
        res     = '0;
        arith   = 1'b0;
        illegal = 1'b0;
        case (s1_mode)
            MODE_A: begin
                case (s1_aop)
                    3'd0:    begin res = ax + bx; arith = 1'b1; end
                    3'd1:    begin res = ax - bx; arith = 1'b1; end
                    3'd2:    res = ax ^ bx;
                    3'd3:    res = ax & bx;
                    3'd4:    res = ax & bx;
                    3'd5:    res = ax | bx;
                    3'd6:    res = ~(ax ^ bx);
                    default: illegal = 1'b1;
                endcase
            end
            MODE_B1: begin
                case (s1_bop)
                    2'd0:    res = ~(ax & bx);
                    2'd1:    begin res = ax + bx; arith = 1'b1; end
                    2'd2:    begin res = ax + bx; arith = 1'b1; end
                    default: illegal = 1'b1;
                endcase
            end
            MODE_B2: begin
                case (s1_bop)
                    2'd0:    res = ax ^ bx;
                    2'd1:    res = ~(ax ^ bx);
                    2'd2:    begin res = ax - RW'(1); arith = 1'b1; end
                    default: begin res = bx + RW'(2); arith = 1'b1; end
                endcase
            end
            default: illegal = 1'b1;
        endcase
        res_ovf = arith && (res[WIDTH] != res[WIDTH-1]);
    end

    // Stage 2: result and flags, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            C         <= '0;
            out_tag   <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                C       <= res;
                out_tag <= s1_tag;
                zero    <= (res == '0);
                ovf     <= res_ovf;
                err     <= illegal;
            end
        end
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, pipelined successor of the 5-bit dual-mode ALU. It keeps the a_en/b_en mode scheme and opcode map, and generalises operand width. It adds valid/ready handshakes on input and output, a 2-stage pipeline with backpressure, a transaction tag, and status flags (zero, overflow, illegal-op). It sits between the operand sequencer and the result writeback in the datapath.

Parameters:
WIDTH, 5, signed operand width in bits; result is WIDTH+1 bits.
TAG_W, 4, width of the transaction tag carried alongside each operation.

Ports:
clk  input  1  clock; all logic on rising edge.
rst_n  input  1  synchronous, active-low reset.
in_valid  input  1  operation presented.
in_ready  output  1  block can accept an operation this cycle.
A  input  WIDTH  signed operand A.
B  input  WIDTH  signed operand B.
a_en  input  1  mode select bit A.
b_en  input  1  mode select bit B.
a_op  input  3  opcode, mode A.
b_op  input  2  opcode, modes B1/B2.
in_tag  input  TAG_W  transaction tag.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
C  output  WIDTH+1  signed result.
out_tag  output  TAG_W  tag of the result.
zero  output  1  C == 0.
ovf  output  1  arithmetic result not representable in WIDTH signed bits.
err  output  1  illegal mode/opcode combination.

Behaviour:
- Accept on the rising edge where in_valid && in_ready. Output transfers on out_valid && out_ready.
- Pipeline:
  - Stage 1 registers A, B, mode, opcode and tag.
  - Stage 2 computes and registers C, flags and tag.
  - Latency is 2 cycles from accept to out_valid when there is no backpressure. Throughput is 1 op per cycle.
- Stall rules:
  - Stage 2 loads when !out_valid || out_ready.
  - Stage 1 advances when stage 2 loads.
  - in_ready = !s1_valid || stage-2-load. in_ready is combinational from out_ready; it does not depend on in_valid.
  - Held results (C, flags, tag) stay stable while out_valid && !out_ready.
- Operands are sign-extended to WIDTH+1 bits before every operation, logical ones included. The result is truncated to WIDTH+1 bits.
- Mode A (a_en=1, b_en=0), a_op:
  - 0: A+B
  - 1: A-B
  - 2: A^B
  - 3: A&B
  - 4: A&B
  - 5: A|B
  - 6: ~(A^B)
  - 7: illegal
- Mode B1 (a_en=0, b_en=1), b_op:
  - 0: ~(A&B)
  - 1: A+B
  - 2: A+B
  - 3: illegal
- Mode B2 (a_en=1, b_en=1), b_op:
  - 0: A^B
  - 1: ~(A^B)
  - 2: A-1
  - 3: B+2
- Mode none (a_en=0, b_en=0): illegal.
- Illegal combinations: C=0, err=1, ovf=0, zero=1. They still occupy a slot and produce out_valid.
- ovf: set only for the add/sub/dec/inc operations, when C[WIDTH] != C[WIDTH-1]. It is 0 for logical operations.
- zero: (C == 0), evaluated on the registered result.
- Reset (rst_n=0 at a clock edge):
  - All valids clear, including mid-operation; in-flight ops are discarded.
  - C=0, out_tag=0, zero=0, ovf=0, err=0, out_valid=0.
  - in_ready=1 from the first cycle after reset deasserts.
- Ordering: results leave in exactly the accept order. No op is dropped or duplicated under any out_ready pattern.
- in_valid may drop without having been accepted; nothing is captured.

Test Plan:
- ADD, WIDTH=5: A=-16, B=-16, a_en=1, b_en=0, a_op=0 -> 2 cycles later C=6'b100000 (-32), ovf=1, zero=0, err=0.
- SUB: A=5, B=7, a_op=1 -> C=6'b111110 (-2), ovf=0. Then XNOR: A=5, B=5, a_op=6 -> C=6'b111111.
- Mode B2:
  - b_op=2, A=-16 -> C=6'b101111 (-17), ovf=1.
  - b_op=3, B=15 -> C=6'b010001 (17), ovf=1.
  - b_op=0, A=3, B=3 -> C=0, zero=1.
- Illegal ops:
  - a_op=7 in mode A -> C=0, err=1.
  - a_en=b_en=0 -> err=1.
  - b_op=3 in mode B1 -> err=1, out_valid still asserted.
- Backpressure: tags 1,2,3,4 streamed back-to-back with out_ready=0 -> in_ready drops after 2 accepts; outputs stay stable. Raise out_ready -> tags emerge 1,2,3,4 on consecutive cycles with correct C.
- Reset mid-operation: assert rst_n=0 for one edge with 2 ops in flight -> out_valid=0 next cycle, both ops lost, in_ready=1. A new op completes normally with 2-cycle latency.
